// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks the destination tags of the instructions in EX, MEM and WB. It stalls decode on a
//   load-use hazard and picks the forwarding source for each decode operand.
//
//   Optional feature: define SCOREBOARD_WB_BYPASS_EN to keep the WB slot and forward from it
//   (code 11). When the macro is undefined, the regfile write-through covers WB. The WB slot is
//   then dropped and code 11 is never produced.
//
// Ports
//   clk                      : single clock, rising edge
//   reset                    : asynchronous active-low reset
//   issue_valid/rd/is_load   : decode instruction moving into EX
//   dec_rs1/rs2, dec_use_*   : decode source registers and whether each one is read
//   flush                    : kill the decode instruction
//   stall                    : decode must hold (combinational)
//   fwd_rs1/fwd_rs2          : 00 regfile, 01 EX, 10 MEM, 11 WB (combinational)
//   stall_count              : saturating count of stall cycles since reset
module hazard_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_is_load,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  fwd_rs1,
    output logic [1:0]  fwd_rs2,
    output logic [15:0] stall_count
);

    logic        ex_valid_q, ex_valid_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_load_q, ex_load_d;
    logic        mem_valid_q;
    logic [4:0]  mem_rd_q;
    logic        mem_load_q;
    logic [15:0] stall_count_q, stall_count_d;

    logic ex_hit_rs1, ex_hit_rs2;
    logic mem_hit_rs1, mem_hit_rs2;
    logic wb_hit_rs1, wb_hit_rs2;

    // x0 never matches, so writes to x0 are harmless even though the slot is valid.
    function automatic logic slot_match(input logic       valid,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs,
                                        input logic       use_src);
        return valid && (rd == rs) && (rs != 5'd0) && use_src;
    endfunction

    // Youngest producer wins. A load in EX has no data yet, so it is never a source.
    function automatic logic [1:0] fwd_select(input logic ex_hit,
                                              input logic ex_load,
                                              input logic mem_hit,
                                              input logic wb_hit);
        if (ex_hit && !ex_load) return 2'b01;
        if (mem_hit)            return 2'b10;
        if (wb_hit)             return 2'b11;
        return 2'b00;
    endfunction

    assign ex_hit_rs1  = slot_match(ex_valid_q, ex_rd_q, dec_rs1, dec_use_rs1);
    assign ex_hit_rs2  = slot_match(ex_valid_q, ex_rd_q, dec_rs2, dec_use_rs2);
    assign mem_hit_rs1 = slot_match(mem_valid_q, mem_rd_q, dec_rs1, dec_use_rs1);
    assign mem_hit_rs2 = slot_match(mem_valid_q, mem_rd_q, dec_rs2, dec_use_rs2);

`ifdef SCOREBOARD_WB_BYPASS_EN
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic        wb_load_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_load_q  <= 1'b0;
        end else begin
            wb_valid_q <= mem_valid_q;
            wb_rd_q    <= mem_rd_q;
            wb_load_q  <= mem_load_q;
        end
    end

    assign wb_hit_rs1 = slot_match(wb_valid_q, wb_rd_q, dec_rs1, dec_use_rs1);
    assign wb_hit_rs2 = slot_match(wb_valid_q, wb_rd_q, dec_rs2, dec_use_rs2);

    // The load flag only matters in EX. Later copies are kept for tracing only.
    logic unused_load;
    assign unused_load = wb_load_q;
`else
    assign wb_hit_rs1 = 1'b0;
    assign wb_hit_rs2 = 1'b0;

    logic unused_load;
    assign unused_load = mem_load_q;
`endif

    always_comb begin
        stall         = 1'b0;
        fwd_rs1       = 2'b00;
        fwd_rs2       = 2'b00;
        ex_valid_d    = 1'b0;
        ex_rd_d       = ex_rd_q;
        ex_load_d     = 1'b0;
        stall_count_d = stall_count_q;

        // A flushed instruction is discarded, so it never needs to be held.
        stall = (ex_hit_rs1 || ex_hit_rs2) && ex_load_q && !flush;

        if (!stall) begin
            fwd_rs1 = fwd_select(ex_hit_rs1, ex_load_q, mem_hit_rs1, wb_hit_rs1);
            fwd_rs2 = fwd_select(ex_hit_rs2, ex_load_q, mem_hit_rs2, wb_hit_rs2);
        end

        if (issue_valid && !stall && !flush) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = issue_rd;
            ex_load_d  = issue_is_load;
        end

        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= 5'd0;
            ex_load_q     <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_rd_q      <= 5'd0;
            mem_load_q    <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rd_q       <= ex_rd_d;
            ex_load_q     <= ex_load_d;
            mem_valid_q   <= ex_valid_q;
            mem_rd_q      <= ex_rd_q;
            mem_load_q    <= ex_load_q;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Each step drives the decode inputs and queues the
// expected outputs. It then pops the queue and compares against the DUT between clock edges.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_is_load;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_rs1;
    logic [1:0]  fwd_rs2;
    logic [15:0] stall_count;

    typedef struct packed {
        logic        st;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic [1:0] WbCode = 2'b11;
`else
    localparam logic [1:0] WbCode = 2'b00;
`endif

    hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_is_load(issue_is_load),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_use_rs1  (dec_use_rs1),
        .dec_use_rs2  (dec_use_rs2),
        .flush        (flush),
        .stall        (stall),
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic iv, input logic [4:0] rd, input logic ld,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic fl);
        issue_valid   = iv;
        issue_rd      = rd;
        issue_is_load = ld;
        dec_rs1       = r1;
        dec_use_rs1   = u1;
        dec_rs2       = r2;
        dec_use_rs2   = u2;
        flush         = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic st, input logic [1:0] f1,
                         input logic [1:0] f2, input logic [15:0] cnt);
        exp_t e;
        e.st  = st;
        e.f1  = f1;
        e.f2  = f2;
        e.cnt = cnt;
        exp_q.push_back(e);
        e = exp_q.pop_front();
        vecs++;
        assert (stall === e.st) else begin
            errs++;
            $error("FAIL %s stall: got %b want %b", tag, stall, e.st);
        end
        vecs++;
        assert (fwd_rs1 === e.f1) else begin
            errs++;
            $error("FAIL %s fwd_rs1: got %b want %b", tag, fwd_rs1, e.f1);
        end
        vecs++;
        assert (fwd_rs2 === e.f2) else begin
            errs++;
            $error("FAIL %s fwd_rs2: got %b want %b", tag, fwd_rs2, e.f2);
        end
        vecs++;
        assert (stall_count === e.cnt) else begin
            errs++;
            $error("FAIL %s stall_count: got %h want %h", tag, stall_count, e.cnt);
        end
    endtask

    initial begin
        logic [15:0] exp_cnt;

        reset = 1'b0;
        // x5 would forward if any slot were live, so this confirms the slots start cleared.
        drive(1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
        cyc();
        cyc();
        check("reset", 1'b0, 2'b00, 2'b00, 16'd0);
        idle();
        reset = 1'b1;
        check("reset_rel", 1'b0, 2'b00, 2'b00, 16'd0);
        cyc();

        // Non-load producer: EX forward, then MEM, then WB.
        drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("add_issue", 1'b0, 2'b00, 2'b00, 16'd0);
        cyc();
        drive(1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        check("fwd_ex", 1'b0, 2'b01, 2'b00, 16'd0);
        cyc();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        check("fwd_mem", 1'b0, 2'b00, 2'b10, 16'd0);
        cyc();
        drive(1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        check("fwd_wb", 1'b0, WbCode, 2'b00, 16'd0);
        cyc();
        idle(); cyc(); cyc(); cyc();

        // Load-use: one stall cycle, then MEM forward.
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("lw_issue", 1'b0, 2'b00, 2'b00, 16'd0);
        cyc();
        drive(1'b1, 5'd8, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        check("lu_stall", 1'b1, 2'b00, 2'b00, 16'd0);
        cyc();
        check("lu_after", 1'b0, 2'b10, 2'b00, 16'd1);
        cyc();
        idle(); cyc(); cyc(); cyc();

        // Three x3 writers back to back: youngest (EX) wins, unused rs2 stays 00.
        drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(); cyc(); cyc();
        drive(1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0);
        check("youngest", 1'b0, 2'b01, 2'b00, 16'd1);
        cyc();
        check("next_mem", 1'b0, 2'b10, 2'b00, 16'd1);
        cyc();
        idle(); cyc(); cyc(); cyc();

        // Load to x0 never stalls or forwards.
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        check("x0_load", 1'b0, 2'b00, 2'b00, 16'd1);
        cyc();
        idle(); cyc(); cyc(); cyc();

        // Stall masks a live MEM match on rs2.
        drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0);
        check("stall_mask", 1'b1, 2'b00, 2'b00, 16'd1);
        cyc();
        check("mask_after", 1'b0, 2'b10, WbCode, 16'd2);
        cyc();
        idle(); cyc(); cyc(); cyc();

        // Flush kills the stall and leaves an EX bubble.
        drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 5'd13, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b1);
        check("flush", 1'b0, 2'b00, 2'b00, 16'd2);
        cyc();
        drive(1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 5'd12, 1'b1, 1'b0);
        check("flush_bub", 1'b0, 2'b00, 2'b10, 16'd2);
        cyc();
        idle(); cyc(); cyc(); cyc();

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 5'd0, 1'b0, 1'b0);
        check("pre_rst", 1'b1, 2'b00, 2'b00, 16'd2);
        reset = 1'b0;
        #1;
        check("async_rst", 1'b0, 2'b00, 2'b00, 16'd0);
        cyc();
        check("rst_held", 1'b0, 2'b00, 2'b00, 16'd0);
        reset = 1'b1;
        idle();
        cyc();

        // Saturation: preload near the top, then stall four more times.
        force dut.stall_count_q = 16'hFFFD;
        #1;
        release dut.stall_count_q;
        exp_cnt = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            check("sat_issue", 1'b0, 2'b00, 2'b00, exp_cnt);
            cyc();
            drive(1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
            check("sat_stall", 1'b1, 2'b00, 2'b00, exp_cnt);
            cyc();
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        idle();
        check("sat_hold", 1'b0, 2'b00, 2'b00, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
